// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and default timing constants for the Pong sound scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pong_sound_pkg;

   localparam int DEF_CW = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [1:0] EV_NONE   = 2'd0;
   localparam logic [1:0] EV_WALL   = 2'd1;
   localparam logic [1:0] EV_PADDLE = 2'd2;
   localparam logic [1:0] EV_MISS   = 2'd3;

   // 100 MHz clock: 100 ms tone, 10 ms gap, 440/880/220 Hz half-periods.
   localparam int unsigned DEF_DUR_CYCLES  = 10_000_000;
   localparam int unsigned DEF_GAP_CYCLES  = 1_000_000;
   localparam int unsigned DEF_WALL_HALF   = 113_636;
   localparam int unsigned DEF_PADDLE_HALF = 56_818;
   localparam int unsigned DEF_MISS_HALF   = 227_272;

endpackage

// File: rtl/sound_event_scheduler_tone_divider.sv
// Square-wave generator: toggles out every 'half' cycles while run is high.
// Latency: first toggle 'half' cycles after the clear cycle; out is registered.
// Backpressure: none; clear has priority over run and zeroes counter and out.
module tone_divider
   import pong_sound_pkg::*;
#(
   parameter int CW = DEF_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic [CW-1:0] half,
   input  logic          run,
   output logic          out
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;

   // Half-period counter: wrap at half-1 and flip the output.
   always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      if (clear) begin
         cnt_d = '0;
         out_d = 1'b0;
      end else if (run) begin
         if (cnt_q == half - 1'b1) begin
            cnt_d = '0;
            out_d = ~out_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/sound_event_scheduler.sv
// Arbitrates wall/paddle/miss event pulses onto one speaker: tone, then silent gap.
// Latency: pulse sampled at edge N+1 sets pending, tone starts at edge N+2.
// Backpressure: none; requests coalesce in pending bits, only miss preempts a tone.
module sound_event_scheduler
   import pong_sound_pkg::*;
#(
   parameter int unsigned DUR_CYCLES  = DEF_DUR_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned WALL_HALF   = DEF_WALL_HALF,
   parameter int unsigned PADDLE_HALF = DEF_PADDLE_HALF,
   parameter int unsigned MISS_HALF   = DEF_MISS_HALF,
   parameter int          CW          = DEF_CW
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       wall_hit,
   input  logic       paddle_hit,
   input  logic       miss,
   output logic       speaker,
   output logic       busy,
   output logic [1:0] active_id
);

   localparam logic [CW-1:0] DUR_LAST = CW'(DUR_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] H_WALL   = CW'(WALL_HALF);
   localparam logic [CW-1:0] H_PADDLE = CW'(PADDLE_HALF);
   localparam logic [CW-1:0] H_MISS   = CW'(MISS_HALF);

   state_t        state_q, state_d;
   logic [2:0]    pending_q, pending_d;   // [0] wall, [1] paddle, [2] miss
   logic [CW-1:0] dur_q, dur_d;
   logic [CW-1:0] gap_q, gap_d;
   logic [CW-1:0] half_q, half_d;
   logic [1:0]    id_q, id_d;
   logic          busy_q, busy_d;

   logic [2:0]    pending_clr;
   logic [1:0]    top_id;
   logic          do_grant;
   logic [1:0]    grant_id;
   logic          div_clear;
   logic          div_run;

   // Highest-priority pending request: miss > paddle > wall.
   always_comb begin
      top_id = EV_NONE;
      if (pending_q[2])      top_id = EV_MISS;
      else if (pending_q[1]) top_id = EV_PADDLE;
      else if (pending_q[0]) top_id = EV_WALL;
   end

   // Sequencer: grant, tone timing, gap timing, preemption and mute/flush.
   always_comb begin
      state_d     = state_q;
      dur_d       = dur_q;
      gap_d       = gap_q;
      half_d      = half_q;
      id_d        = id_q;
      pending_clr = 3'b000;
      do_grant    = 1'b0;
      grant_id    = EV_NONE;
      div_clear   = 1'b0;
      div_run     = 1'b0;

      case (state_q)
         IDLE: begin
            if (pending_q != 3'b000) begin
               do_grant = 1'b1;
               grant_id = top_id;
            end
         end
         PLAY: begin
            if (pending_q[2] && (id_q != EV_MISS)) begin
               // Miss restarts the tone; the interrupted event is dropped.
               do_grant = 1'b1;
               grant_id = EV_MISS;
            end else if (dur_q == DUR_LAST) begin
               state_d   = GAP;
               gap_d     = '0;
               div_clear = 1'b1;
            end else begin
               dur_d   = dur_q + 1'b1;
               div_run = 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
               id_d    = EV_NONE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            id_d    = EV_NONE;
         end
      endcase

      if (do_grant) begin
         state_d   = PLAY;
         dur_d     = '0;
         id_d      = grant_id;
         div_clear = 1'b1;
         case (grant_id)
            EV_MISS: begin
               half_d      = H_MISS;
               pending_clr = 3'b100;
            end
            EV_PADDLE: begin
               half_d      = H_PADDLE;
               pending_clr = 3'b010;
            end
            default: begin
               half_d      = H_WALL;
               pending_clr = 3'b001;
            end
         endcase
      end

      // A new pulse wins over a same-cycle grant clear.
      pending_d = (pending_q & ~pending_clr) | {miss, paddle_hit, wall_hit};

      if (!enable) begin
         state_d   = IDLE;
         pending_d = 3'b000;
         dur_d     = '0;
         gap_d     = '0;
         id_d      = EV_NONE;
         div_clear = 1'b1;
         div_run   = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 3'b000;
         dur_q     <= '0;
         gap_q     <= '0;
         half_q    <= '0;
         id_q      <= EV_NONE;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         dur_q     <= dur_d;
         gap_q     <= gap_d;
         half_q    <= half_d;
         id_q      <= id_d;
         busy_q    <= busy_d;
      end
   end

   tone_divider #(
      .CW (CW)
   ) u_tone_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (div_clear),
      .half  (half_q),
      .run   (div_run),
      .out   (speaker)
   );

   assign busy      = busy_q;
   assign active_id = id_q;

endmodule

// File: doc/sound_event_scheduler.md
Name: sound_event_scheduler

Overview:
- Shares the single speaker tone path among three Pong collision-event requesters: wall bounce, paddle hit, ball miss.
- Latches single-cycle event pulses from the game logic and arbitrates them by priority.
- For each granted event, plays a square-wave tone of fixed duration, then a silent gap.
- Sits beside the game/VGA logic on the 100 MHz system clock and drives the board speaker pin.

Parameters:
- DUR_CYCLES, 10_000_000, tone length in clocks (100 ms).
- GAP_CYCLES, 1_000_000, silence after each tone in clocks (10 ms).
- WALL_HALF, 113_636, half-period of the wall tone in clocks (440 Hz).
- PADDLE_HALF, 56_818, half-period of the paddle tone in clocks (880 Hz).
- MISS_HALF, 227_272, half-period of the miss tone in clocks (220 Hz).
- CW, 24, width of all internal counters; every default value must be < 2^CW.

Ports:
- Clock  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-low reset.
- enable  in  1  sound enable; 0 = mute and flush.
- wall_hit  in  1  single-cycle request pulse.
- paddle_hit  in  1  single-cycle request pulse.
- miss  in  1  single-cycle request pulse.
- speaker  out  1  square-wave output.
- busy  out  1  high in PLAY or GAP.
- active_id  out  2  0 = none, 1 = wall, 2 = paddle, 3 = miss.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - state = IDLE.
  - pending[2:0], speaker, busy, active_id, and all counters = 0.
- Pending latches:
  - A pulse sets its pending bit on the next clock edge. Repeat pulses of the same event coalesce into one bit.
  - If a pulse arrives on the same cycle its bit is being cleared by a grant, the set wins and the bit stays 1.
- Priority: miss > paddle > wall. Fixed, no rotation.
- IDLE:
  - If any pending bit is set, grant the highest-priority one on that edge: clear its bit, load half = *_HALF, set dur = 0 and the half counter = 0, set active_id, enter PLAY.
  - speaker stays 0 on the grant edge.
  - Latency: pulse at edge N → pending at N+1 → PLAY at N+2. busy = 1 from N+2.
- PLAY:
  - Half counter increments each cycle. On reaching half-1 it wraps to 0 and speaker toggles. The first toggle is half cycles after PLAY entry.
  - dur increments each cycle. On dur == DUR_CYCLES-1: next state GAP, speaker = 0, gap counter = 0.
- Preemption:
  - A pending miss while playing wall or paddle restarts PLAY immediately with the miss tone: counters reloaded, speaker = 0, miss bit cleared.
  - The interrupted event is dropped, not requeued.
  - Wall or paddle requests during PLAY or GAP only queue.
- GAP:
  - speaker = 0 and active_id keeps the last event.
  - On gap counter == GAP_CYCLES-1: next state IDLE, active_id = 0, busy = 0.
  - No preemption in GAP.
- enable = 0 (synchronous, checked every cycle, overrides all other rules):
  - Next state IDLE; pending, speaker, busy, and active_id cleared.
  - Incoming pulses are ignored while enable = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter arithmetic is unsigned CW bits and compares only with ==, so wrap-around never occurs.

Decomposition:
- Package pong_sound_pkg holds:
  - The state enum {IDLE, PLAY, GAP}.
  - Event-ID constants EV_NONE = 0, EV_WALL = 1, EV_PADDLE = 2, EV_MISS = 3.
  - Default DUR, GAP and *_HALF constants.
- One sub-module, tone_divider.
  - Ports: Clock, Reset, clear, half[CW-1:0], run, out.
  - Owns the half counter and the speaker toggle.
  - clear zeroes both the counter and out.

Test Plan (bench overrides DUR_CYCLES = 20, GAP_CYCLES = 4, WALL_HALF = 3, PADDLE_HALF = 2, MISS_HALF = 5):
- Reset low mid-PLAY → speaker, busy and active_id read 0 immediately without a clock edge; after release, stay IDLE with no pending.
- Single wall_hit at edge 0:
  - busy rises at edge 2 with active_id = 1.
  - speaker toggles every 3 cycles for 20 cycles.
  - Then 4 cycles of speaker = 0, then busy = 0 and active_id = 0.
- wall_hit and paddle_hit on the same cycle → paddle (id 2) plays first; wall (id 1) follows right after the gap; two pending bits each serviced once.
- Paddle playing, miss pulse at PLAY cycle 7 → within 2 edges active_id = 3, speaker restarts from 0 with half-period 5, full 20-cycle duration; paddle is not replayed.
- Three wall_hit pulses during one PLAY → exactly one further wall tone after the gap.
- enable dropped mid-PLAY with a pending paddle → next edge IDLE, speaker = 0, pending cleared; re-enable → no tone until a new pulse.
